axi4_stream_arb: RTL and testbench

AXI4_STREAM_ARB -- requirements
Module: axi4_stream_arb

---
 rtl/axi4_stream_pkg.sv | 14 +
 rtl/axi4_stream_if.sv | 16 +
 rtl/axi4_stream_arb_rr.sv | 30 +++
 rtl/axi4_stream_arb.sv | 92 +++++++++
 tb/tb_axi4_stream_arb.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream definitions: switch state encoding and index-width helper.
package axi4_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // A single-port switch still needs a 1-bit index vector.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle: s = driving side, d = receiving side.
interface axi4_stream_if #(
  parameter int  DN = 1,
  parameter type DT = logic [8-1:0]
);

  logic          TVALID;
  logic          TREADY;
  DT [DN-1:0]    TDATA;
  logic [DN-1:0] TKEEP;
  logic          TLAST;

  modport s (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
  modport d (input TVALID, TDATA, TKEEP, TLAST, output TREADY);

endinterface

// File: rtl/axi4_stream_arb_rr.sv
// Combinational round-robin search: first set req bit scanning up from ptr+1.
module axi4_stream_arb_rr
  import axi4_stream_pkg::*;
#(
  parameter int SN = 2,
  parameter int SW = sel_width(SN)
)(
  input  logic [SN-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt,
  output logic          vld
);

  logic [SW-1:0] idx;

  // ptr itself is visited last, so the previous owner has lowest priority.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= SN; k++) begin
      idx = SW'((int'(ptr) + k) % SN);
      if (!vld && req[idx]) begin
        gnt = idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_arb.sv
// Packet-level round-robin AXI4-Stream switch: N inputs to one output,
// grant held from arbitration until the TLAST beat is accepted.
module axi4_stream_arb
  import axi4_stream_pkg::*;
#(
  parameter int  SN = 2,
  parameter int  SW = sel_width(SN),
  parameter int  DN = 1,
  parameter type DT = logic [8-1:0]
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [SN-1:0] ena,
  output logic [SW-1:0] sel,
  output logic          busy,
  axi4_stream_if.d      sti [SN-1:0],
  axi4_stream_if.s      sto
);

  arb_state_t            state_reg, state_next;
  logic [SW-1:0]         sel_reg, sel_next;
  logic [SW-1:0]         ptr_reg, ptr_next;
  logic [SW-1:0]         rr_gnt;
  logic                  rr_vld;
  logic                  fwd;
  logic [SN-1:0]         tvalid;
  logic [SN-1:0]         tlast;
  logic [SN-1:0][DN-1:0] tkeep;
  DT    [SN-1:0][DN-1:0] tdata;

  for (genvar gi = 0; gi < SN; gi++) begin : g_port
    assign tvalid[gi]     = sti[gi].TVALID;
    assign tdata[gi]      = sti[gi].TDATA;
    assign tkeep[gi]      = sti[gi].TKEEP;
    assign tlast[gi]      = sti[gi].TLAST;
    assign sti[gi].TREADY = fwd && (sel_reg == SW'(gi)) && sto.TREADY;
  end

  // Forwarding is cut while rst is high so nothing moves during reset.
  assign fwd  = (state_reg == BUSY) && !rst;
  assign busy = fwd;
  assign sel  = rst ? '0 : sel_reg;

  assign sto.TVALID = fwd && tvalid[sel_reg];
  assign sto.TDATA  = tdata[sel_reg];
  assign sto.TKEEP  = tkeep[sel_reg];
  assign sto.TLAST  = tlast[sel_reg];

  axi4_stream_arb_rr #(
    .SN (SN),
    .SW (SW)
  ) u_rr (
    .req (tvalid & ena),
    .ptr (ptr_reg),
    .gnt (rr_gnt),
    .vld (rr_vld)
  );

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (rr_vld) begin
          state_next = BUSY;
          sel_next   = rr_gnt;
        end
      end
      BUSY: begin
        // Returning to IDLE forces the one-cycle bubble before the next grant.
        if (sto.TVALID && sto.TREADY && tlast[sel_reg]) begin
          state_next = IDLE;
          ptr_next   = sel_reg;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= SW'(SN - 1);
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_axi4_stream_arb.sv
// Self-checking bench for axi4_stream_arb (4 ports, 8-bit data): per-port
// packet sources, an output scoreboard, a vector table and corner sequences.
module tb_axi4_stream_arb;

  localparam int SN = 4;
  typedef logic [7:0] dt_t;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [3:0]      ena;
    logic [3:0][3:0] pkts;
    logic [3:0]      len;
    logic [3:0]      nrdy;
    logic [3:0]      n;
    logic [7:0][1:0] order;
    logic            gap3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ena = 4'hF;
  logic [1:0] sel;
  logic       busy;
  logic       sto_ready = 1'b1;
  logic [3:0] tvalid_drv = '0;
  logic [3:0] tlast_drv = '0;
  logic [3:0] tready_mon;
  dt_t        tdata_drv [SN];

  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sti [SN-1:0] ();
  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sto ();

  for (genvar gi = 0; gi < SN; gi++) begin : g_src
    assign sti[gi].TVALID = tvalid_drv[gi];
    assign sti[gi].TDATA  = tdata_drv[gi];
    assign sti[gi].TKEEP  = 1'b1;
    assign sti[gi].TLAST  = tlast_drv[gi];
    assign tready_mon[gi] = sti[gi].TREADY;
  end
  assign sto.TREADY = sto_ready;

  axi4_stream_arb #(
    .SN (SN),
    .SW (2),
    .DN (1),
    .DT (logic [7:0])
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .sel  (sel),
    .busy (busy),
    .sti  (sti),
    .sto  (sto)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  beat_t      sb [$];
  int         grant_times [$];
  logic [3:0] ready_seen = '0;
  logic [3:0] fire_mask = '0;
  logic       busy_prev = 1'b0;
  int         src_pkts [SN];
  int         src_len [SN];
  int         src_beat [SN];
  int         src_seq [SN];
  int         exp_seq [SN];
  dt_t        src_base [SN];
  vec_t       vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic update_drive();
    for (int p = 0; p < SN; p++) begin
      tvalid_drv[p] = (src_pkts[p] > 0);
      tdata_drv[p]  = src_base[p] + 8'(src_seq[p]);
      tlast_drv[p]  = (src_beat[p] == src_len[p] - 1);
    end
  endtask

  task automatic src_reset();
    for (int p = 0; p < SN; p++) begin
      src_pkts[p] = 0;
      src_len[p]  = 1;
      src_beat[p] = 0;
      src_seq[p]  = 0;
      exp_seq[p]  = 0;
      src_base[p] = 8'(p * 64);
    end
    sb.delete();
    update_drive();
  endtask

  task automatic push_beat(input int p, input logic last);
    beat_t e;
    e.port = 2'(p);
    e.data = src_base[p] + 8'(exp_seq[p]);
    e.last = last;
    sb.push_back(e);
    exp_seq[p]++;
  endtask

  task automatic push_pkt(input int p);
    for (int b = 0; b < src_len[p]; b++) push_beat(p, b == src_len[p] - 1);
  endtask

  task automatic monitor();
    logic [3:0] allowed;
    beat_t      e;
    fire_mask  = tvalid_drv & tready_mon;
    ready_seen = ready_seen | tready_mon;
    allowed    = busy ? (4'b0001 << sel) : 4'b0000;
    chk("ready_route", 32'(tready_mon & ~allowed), 32'd0);
    if (!busy) chk("idle_tvalid", 32'(sto.TVALID), 32'd0);
    else chk("ready_pass", 32'(tready_mon[sel]), 32'(sto_ready));
    if (busy && !busy_prev) grant_times.push_back(cyc);
    busy_prev = busy;
    if (sto.TVALID && sto_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected cycle=%0d actual sel=%0d data=%0h required no beat", cyc, sel, sto.TDATA);
      end else begin
        e = sb.pop_front();
        chk("sb_beat", 32'({sel, sto.TDATA, sto.TLAST}), 32'({e.port, e.data, e.last}));
      end
    end
  endtask

  task automatic advance();
    for (int p = 0; p < SN; p++) begin
      if (fire_mask[p]) begin
        src_seq[p]++;
        if (src_beat[p] == src_len[p] - 1) begin
          src_beat[p] = 0;
          src_pkts[p]--;
        end else begin
          src_beat[p]++;
        end
      end
    end
    update_drive();
  endtask

  // One clock: sample just after the negedge, advance sources after the posedge.
  task automatic step();
    #1;
    monitor();
    @(posedge clk);
    #1;
    advance();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    update_drive();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // ena, pkts per port {3,2,1,0}, len, never-ready mask, n, expected order (index 0 first), gap check
    vt[0] = '{ena: 4'hF, pkts: {4'd0, 4'd1, 4'd0, 4'd1}, len: 4'd2, nrdy: 4'b0000, n: 4'd2,
              order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0}, gap3: 1'b0};
    vt[1] = '{ena: 4'hF, pkts: {4'd2, 4'd2, 4'd2, 4'd2}, len: 4'd2, nrdy: 4'b0000, n: 4'd8,
              order: {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, gap3: 1'b1};
    vt[2] = '{ena: 4'b1010, pkts: {4'd2, 4'd9, 4'd2, 4'd9}, len: 4'd2, nrdy: 4'b0101, n: 4'd4,
              order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1}, gap3: 1'b0};
    vt[3] = '{ena: 4'hF, pkts: {4'd1, 4'd0, 4'd1, 4'd0}, len: 4'd1, nrdy: 4'b0000, n: 4'd2,
              order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1}, gap3: 1'b0};
    vt[4] = '{ena: 4'hF, pkts: {4'd1, 4'd0, 4'd0, 4'd1}, len: 4'd3, nrdy: 4'b0000, n: 4'd2,
              order: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0}, gap3: 1'b1};

    @(negedge clk);

    // First grant timing and the mandatory bubble (ports 0 and 2 valid).
    src_reset();
    src_pkts[0] = 1; src_len[0] = 2;
    src_pkts[2] = 1; src_len[2] = 2;
    update_drive();
    push_pkt(0);
    push_pkt(2);
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_tvalid", 32'(sto.TVALID), 32'd0);
    chk("rst_tready", 32'(tready_mon), 32'd0);
    rst = 1'b0;
    chk("c1_idle", 32'(busy), 32'd0);
    step();
    chk("c2_busy", 32'(busy), 32'd1);
    chk("c2_sel", 32'(sel), 32'd0);
    step();
    chk("c3_busy", 32'(busy), 32'd1);
    step();
    chk("bubble", 32'(busy), 32'd0);
    step();
    chk("next_busy", 32'(busy), 32'd1);
    chk("next_sel", 32'(sel), 32'd2);
    run_until_empty(50);

    // Output stall with ena cleared mid-packet on port 1.
    src_reset();
    src_base[1] = 8'hA5;
    src_pkts[1] = 1; src_len[1] = 2;
    ena = 4'hF;
    do_reset();
    push_pkt(1);
    step();
    sto_ready = 1'b0;
    ena = 4'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_sel", 32'(sel), 32'd1);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_tvalid", 32'(sto.TVALID), 32'd1);
      chk("stall_data", 32'(sto.TDATA), 32'hA5);
      step();
    end
    sto_ready = 1'b1;
    run_until_empty(20);
    step();
    chk("stall_done", 32'(busy), 32'd0);
    ena = 4'hF;

    // Reset on the second beat of a 4-beat packet from port 3.
    src_reset();
    src_pkts[3] = 1; src_len[3] = 4;
    do_reset();
    push_beat(3, 1'b0);
    step();
    chk("abort_sel", 32'(sel), 32'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tready", 32'(tready_mon), 32'd0);
    chk("abort_tvalid", 32'(sto.TVALID), 32'd0);
    src_beat[3] = 0;
    src_pkts[0] = 1; src_len[0] = 1;
    update_drive();
    push_pkt(0);
    push_pkt(3);
    step();
    chk("abort_regrant", 32'(sel), 32'd0);
    run_until_empty(30);

    // Single-beat packet from port 2 moves ptr to 2.
    src_reset();
    src_pkts[2] = 1; src_len[2] = 1;
    do_reset();
    push_pkt(2);
    step();
    chk("single_sel", 32'(sel), 32'd2);
    src_pkts[0] = 1; src_len[0] = 1;
    src_pkts[3] = 1; src_len[3] = 1;
    update_drive();
    push_pkt(3);
    push_pkt(0);
    step();
    chk("single_len", 32'(busy), 32'd0);
    step();
    chk("single_ptr", 32'(sel), 32'd3);
    run_until_empty(30);

    // Vector table: grant order, never-ready ports and packet spacing.
    for (int t = 0; t < 5; t++) begin
      src_reset();
      ena = vt[t].ena;
      for (int p = 0; p < SN; p++) begin
        src_pkts[p] = int'(vt[t].pkts[p]);
        src_len[p]  = int'(vt[t].len);
      end
      do_reset();
      for (int k = 0; k < int'(vt[t].n); k++) push_pkt(int'(vt[t].order[k]));
      ready_seen = '0;
      grant_times.delete();
      run_until_empty(200);
      step();
      step();
      chk($sformatf("vec%0d_nrdy", t), 32'(ready_seen & vt[t].nrdy), 32'd0);
      chk($sformatf("vec%0d_grants", t), 32'(grant_times.size()), 32'(vt[t].n));
      if (vt[t].gap3) begin
        for (int k = 1; k < grant_times.size(); k++)
          chk($sformatf("vec%0d_gap", t), 32'(grant_times[k] - grant_times[k-1]), 32'(int'(vt[t].len) + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
